// File: rtl/gpio_ports_pkg.sv
// ============================================================================
// Module   : gpio_ports_pkg
// Brief    : Register map and control FSM encoding for the GPIO port bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gpio_ports_pkg;

  localparam logic [1:0] ADDR_DOUT = 2'd0;
  localparam logic [1:0] ADDR_DIR  = 2'd1;
  localparam logic [1:0] ADDR_DIN  = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/gpio_ports_chan.sv
// ============================================================================
// Module   : gpio_ports_chan
// Brief    : One channel: output latch, direction, input synchroniser,
//            sticky rising-edge flags and per-bit tri-state drivers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gpio_ports_chan #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we_dout,
  input  logic             i_we_dir,
  input  logic             i_we_edge,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_dout,
  output logic [WIDTH-1:0] o_dir,
  output logic [WIDTH-1:0] o_din,
  output logic [WIDTH-1:0] o_edge,
  output logic [WIDTH-1:0] o_edge_nxt,
  inout  wire  [WIDTH-1:0] io_pins
);

  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_edge_nxt;

  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

  // A new rising edge overrides a simultaneous write-1-to-clear.
  assign w_edge_nxt = (i_we_edge ? (r_edge & ~i_wdata) : r_edge) | w_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
      r_dir  <= '0;
      r_prev <= '0;
      r_edge <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= io_pins;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
      r_edge <= w_edge_nxt;
      if (i_we_dout) begin
        r_dout <= i_wdata;
      end
      if (i_we_dir) begin
        r_dir <= i_wdata;
      end
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_drv
    assign io_pins[b] = r_dir[b] ? r_dout[b] : 1'bz;
  end

  assign o_dout     = r_dout;
  assign o_dir      = r_dir;
  assign o_din      = r_sync[SYNC_STAGES-1];
  assign o_edge     = r_edge;
  assign o_edge_nxt = w_edge_nxt;

endmodule

`default_nettype wire

// File: rtl/gpio_ports.sv
// ============================================================================
// Module   : gpio_ports
// Brief    : Multi-channel bidirectional port bank with a single-outstanding
//            request/response register interface and a level interrupt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gpio_ports
  import gpio_ports_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int CHANNELS    = 2,
  parameter  int SYNC_STAGES = 2,
  localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [CW-1:0]             req_chan,
  input  logic [1:0]                req_addr,
  input  logic [WIDTH-1:0]          req_wdata,
  output logic                      rsp_valid,
  output logic [WIDTH-1:0]          rsp_rdata,
  inout  wire  [CHANNELS*WIDTH-1:0] pins,
  output logic                      irq
);

  state_e           r_state;
  logic             r_ready;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rdata;
  logic             r_irq;

  logic             w_accept;
  logic             w_we;
  logic [WIDTH-1:0] w_rdata;
  logic             w_irq_nxt;

  logic [WIDTH-1:0] w_dout     [CHANNELS];
  logic [WIDTH-1:0] w_dir      [CHANNELS];
  logic [WIDTH-1:0] w_din      [CHANNELS];
  logic [WIDTH-1:0] w_edge     [CHANNELS];
  logic [WIDTH-1:0] w_edge_nxt [CHANNELS];

  assign w_accept = req_valid && r_ready;
  assign w_we     = w_accept && req_write;

  // Out-of-range channel indices never match a channel, so they fall through
  // to "write ignored, read returns zero".
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    gpio_ports_chan #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .i_we_dout  (w_we && (req_chan == CW'(c)) && (req_addr == ADDR_DOUT)),
      .i_we_dir   (w_we && (req_chan == CW'(c)) && (req_addr == ADDR_DIR)),
      .i_we_edge  (w_we && (req_chan == CW'(c)) && (req_addr == ADDR_EDGE)),
      .i_wdata    (req_wdata),
      .o_dout     (w_dout[c]),
      .o_dir      (w_dir[c]),
      .o_din      (w_din[c]),
      .o_edge     (w_edge[c]),
      .o_edge_nxt (w_edge_nxt[c]),
      .io_pins    (pins[c*WIDTH +: WIDTH])
    );
  end

  always_comb begin
    w_rdata = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (!req_write && (req_chan == CW'(c))) begin
        case (req_addr)
          ADDR_DOUT: w_rdata = w_dout[c];
          ADDR_DIR:  w_rdata = w_dir[c];
          ADDR_DIN:  w_rdata = w_din[c];
          ADDR_EDGE: w_rdata = w_edge[c];
          default:   w_rdata = '0;
        endcase
      end
    end
  end

  always_comb begin
    w_irq_nxt = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_irq_nxt = w_irq_nxt | (|w_edge_nxt[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_irq <= w_irq_nxt;
      case (r_state)
        ST_IDLE: begin
          r_rsp_valid <= 1'b0;
          if (w_accept) begin
            r_state     <= ST_RESP;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rdata     <= w_rdata;
          end
        end
        ST_RESP: begin
          r_state     <= ST_IDLE;
          r_ready     <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_ready     <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign irq       = r_irq;

endmodule

`default_nettype wire
